cam_dvp_capture: RTL

Camera-side front end for the OV7725 DVP bus, clocked by the camera pixel clock. It frame-aligns to VSYNC and packs each byte pair on DATA_I, qualified by H_REF_I, into one RGB565 pixel. It pushes pixels with start-of-frame and end-of-line markers into the line buffer write port feeding the LCD line writer. It also checks line and frame geometry and reports sticky error flags and counters.

---
 rtl/cam_dvp_capture.sv | 192 +++++++++++++++++++
 1 files changed

// File: rtl/cam_dvp_capture.sv
// OV7725 DVP capture front end: frame-aligns to VSYNC, packs byte pairs into
// RGB565 pixels with sof/eol markers, and tracks line/frame geometry errors.
module cam_dvp_capture #(
    parameter int H_ACTIVE = 320,
    parameter int V_ACTIVE = 240,
    parameter int CNT_W    = 10
) (
    input  logic             PCLK_I,
    input  logic             RESETN_I,
    input  logic             enable_i,
    input  logic             V_SYNC_I,
    input  logic             H_REF_I,
    input  logic [7:0]       DATA_I,
    input  logic             buf_full_i,
    output logic [15:0]      pix_data_o,
    output logic             pix_valid_o,
    output logic             sof_o,
    output logic             eol_o,
    output logic [CNT_W-1:0] line_cnt_o,
    output logic [7:0]       frame_cnt_o,
    output logic             line_err_o,
    output logic             frame_err_o,
    output logic             ovf_err_o
);
    localparam int BC_W = CNT_W + 2;
    localparam logic [BC_W-1:0]  LINE_BYTES = BC_W'(2 * H_ACTIVE);
    localparam logic [CNT_W-1:0] H_LAST     = CNT_W'(H_ACTIVE - 1);
    localparam logic [CNT_W-1:0] V_LINES    = CNT_W'(V_ACTIVE);

    typedef enum logic [1:0] {IDLE, WAIT_VS, WAIT_FS, ACTIVE} state_e;
    state_e state_q, state_d;

    logic [7:0] d_q;
    logic       href_q, href_p_q, vs_q, vs_p_q, en_q;
    logic       vs_rise, vs_fall, href_fall, en_rise;

    always_ff @(posedge PCLK_I or negedge RESETN_I) begin
        if (!RESETN_I) begin
            d_q      <= '0;
            href_q   <= 1'b0;
            href_p_q <= 1'b0;
            vs_q     <= 1'b0;
            vs_p_q   <= 1'b0;
            en_q     <= 1'b0;
        end else begin
            d_q      <= DATA_I;
            href_q   <= H_REF_I;
            href_p_q <= href_q;
            vs_q     <= V_SYNC_I;
            vs_p_q   <= vs_q;
            en_q     <= enable_i;
        end
    end

    assign vs_rise   = vs_q & ~vs_p_q;
    assign vs_fall   = ~vs_q & vs_p_q;
    assign href_fall = ~href_q & href_p_q;
    assign en_rise   = enable_i & ~en_q;

    always_ff @(posedge PCLK_I or negedge RESETN_I) begin
        if (!RESETN_I) state_q <= IDLE;
        else           state_q <= state_d;
    end

    // A frame is only entered through a complete VSYNC pulse seen while enabled.
    always_comb begin
        state_d = state_q;
        if (!enable_i) begin
            state_d = IDLE;
        end else begin
            case (state_q)
                IDLE:    state_d = WAIT_VS;
                WAIT_VS: if (vs_rise) state_d = WAIT_FS;
                WAIT_FS: if (vs_fall) state_d = ACTIVE;
                ACTIVE:  if (vs_rise) state_d = WAIT_FS;
                default: state_d = IDLE;
            endcase
        end
    end

    logic capturing, frame_start, frame_end;
    always_comb begin
        capturing   = (state_q == ACTIVE);
        frame_start = (state_q == WAIT_FS) && (state_d == ACTIVE);
        frame_end   = (state_q == ACTIVE) && (state_d == WAIT_FS);
    end

    logic             byte_vld, line_end;
    logic             phase_q;
    logic [7:0]       hi_q;
    logic [BC_W-1:0]  byte_cnt_q;
    logic [CNT_W-1:0] pix_idx_q;
    logic             pend_q, pend_eol_q;
    logic [15:0]      pend_data_q;

    assign byte_vld = capturing & href_q;
    assign line_end = capturing & href_fall;

    always_ff @(posedge PCLK_I or negedge RESETN_I) begin
        if (!RESETN_I) begin
            phase_q     <= 1'b0;
            hi_q        <= '0;
            byte_cnt_q  <= '0;
            pix_idx_q   <= '0;
            pend_q      <= 1'b0;
            pend_eol_q  <= 1'b0;
            pend_data_q <= '0;
        end else begin
            pend_q <= 1'b0;
            if (!capturing || href_fall) begin
                phase_q    <= 1'b0;
                byte_cnt_q <= '0;
                pix_idx_q  <= '0;
            end else if (byte_vld) begin
                phase_q <= ~phase_q;
                if (byte_cnt_q != '1) byte_cnt_q <= byte_cnt_q + 1'b1;
                if (!phase_q) begin
                    hi_q <= d_q;
                end else begin
                    // Index saturates so overlong lines can never wrap back into range.
                    if (pix_idx_q != '1) pix_idx_q <= pix_idx_q + 1'b1;
                    pend_q      <= (pix_idx_q <= H_LAST);
                    pend_eol_q  <= (pix_idx_q == H_LAST);
                    pend_data_q <= {hi_q, d_q};
                end
            end
        end
    end

    logic        emit, drop, first_pix_q;
    logic [15:0] pix_data_q;
    logic        pix_valid_q, sof_q, eol_q;

    assign emit = pend_q & (state_d == ACTIVE) & ~buf_full_i;
    assign drop = pend_q & (state_d == ACTIVE) & buf_full_i;

    // first_pix only clears on a real emission, so a dropped sof pixel hands sof on.
    always_ff @(posedge PCLK_I or negedge RESETN_I) begin
        if (!RESETN_I) begin
            first_pix_q <= 1'b0;
            pix_data_q  <= '0;
            pix_valid_q <= 1'b0;
            sof_q       <= 1'b0;
            eol_q       <= 1'b0;
        end else begin
            pix_valid_q <= emit;
            sof_q       <= emit & first_pix_q;
            eol_q       <= emit & pend_eol_q;
            if (emit) pix_data_q <= pend_data_q;
            if (frame_start)   first_pix_q <= 1'b1;
            else if (emit)     first_pix_q <= 1'b0;
        end
    end

    logic [CNT_W-1:0] line_cnt_q;
    logic [7:0]       frame_cnt_q;
    logic             line_err_q, frame_err_q, ovf_err_q;

    always_ff @(posedge PCLK_I or negedge RESETN_I) begin
        if (!RESETN_I) begin
            line_cnt_q  <= '0;
            frame_cnt_q <= '0;
            line_err_q  <= 1'b0;
            frame_err_q <= 1'b0;
            ovf_err_q   <= 1'b0;
        end else begin
            if (frame_start)                        line_cnt_q <= '0;
            else if (line_end && line_cnt_q != '1)  line_cnt_q <= line_cnt_q + 1'b1;
            if (frame_end && line_cnt_q == V_LINES) frame_cnt_q <= frame_cnt_q + 1'b1;
            if (en_rise) begin
                line_err_q  <= 1'b0;
                frame_err_q <= 1'b0;
                ovf_err_q   <= 1'b0;
            end else begin
                if (line_end && byte_cnt_q != LINE_BYTES) line_err_q  <= 1'b1;
                if (frame_end && line_cnt_q != V_LINES)   frame_err_q <= 1'b1;
                if (drop)                                 ovf_err_q   <= 1'b1;
            end
        end
    end

    assign pix_data_o  = pix_data_q;
    assign pix_valid_o = pix_valid_q;
    assign sof_o       = sof_q;
    assign eol_o       = eol_q;
    assign line_cnt_o  = line_cnt_q;
    assign frame_cnt_o = frame_cnt_q;
    assign line_err_o  = line_err_q;
    assign frame_err_o = frame_err_q;
    assign ovf_err_o   = ovf_err_q;

endmodule
